// File: rtl/mc_int_unit.sv
// Interrupt unit for the multi-cycle CPU: synchronises irq lines, latches rising
// edges as pending, presents the highest-priority enabled request and tracks EPC/cause.
module mc_int_unit #(
    parameter int unsigned          NUM_IRQ     = 4,
    parameter int unsigned          ADDR_W      = 32,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [ADDR_W-1:0]    VEC_BASE    = 32'h0000_0004,
    parameter int unsigned          VEC_STRIDE  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic                irq_en_wr,
    input  logic [NUM_IRQ-1:0]  irq_en_din,
    output logic [NUM_IRQ-1:0]  irq_en,
    output logic [NUM_IRQ-1:0]  pending,
    output logic                int_req,
    output logic [ADDR_W-1:0]   int_vector,
    input  logic                int_ack,
    input  logic [ADDR_W-1:0]   pc_next,
    input  logic                eret,
    output logic [ADDR_W-1:0]   epc,
    output logic [NUM_IRQ-1:0]  cause,
    output logic                in_service
);

    localparam int unsigned       IDX_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(VEC_STRIDE);

    typedef enum logic {IDLE = 1'b0, SERVICE = 1'b1} state_t;

    state_t               state_reg, state_next;
    logic [NUM_IRQ-1:0]   sync_out;
    logic [NUM_IRQ-1:0]   prev_reg;
    logic [NUM_IRQ-1:0]   rise;
    logic [NUM_IRQ-1:0]   pending_reg, pending_next;
    logic [NUM_IRQ-1:0]   irq_en_reg;
    logic [NUM_IRQ-1:0]   cause_reg;
    logic [ADDR_W-1:0]    epc_reg;
    logic [NUM_IRQ-1:0]   winner_oh;
    logic [IDX_W-1:0]     winner_idx;
    logic                 any_win;
    logic                 accept;

    // Per-channel synchroniser chain; the last stage feeds the edge detector.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], irq[gi]};
                end
            end
            assign sync_out[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    assign rise = sync_out & ~prev_reg;

    // Scan from the top so the lowest-index request is the one left standing.
    always_comb begin
        any_win    = 1'b0;
        winner_idx = '0;
        winner_oh  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_reg[i] && irq_en_reg[i]) begin
                any_win      = 1'b1;
                winner_idx   = IDX_W'(i);
                winner_oh    = '0;
                winner_oh[i] = 1'b1;
            end
        end
    end

    assign int_req    = any_win && (state_reg == IDLE);
    assign int_vector = VEC_BASE + ADDR_W'(winner_idx) * STRIDE;
    assign accept     = int_ack && int_req;

    // A new edge on the channel being acknowledged survives the clear.
    assign pending_next = (pending_reg & ~(accept ? winner_oh : '0)) | rise;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SERVICE;
            SERVICE: if (eret)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            prev_reg    <= '0;
            pending_reg <= '0;
            irq_en_reg  <= '0;
            epc_reg     <= '0;
            cause_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            prev_reg    <= sync_out;
            pending_reg <= pending_next;
            if (irq_en_wr) begin
                irq_en_reg <= irq_en_din;
            end
            if (accept) begin
                epc_reg   <= pc_next;
                cause_reg <= winner_oh;
            end
        end
    end

    assign irq_en     = irq_en_reg;
    assign pending    = pending_reg;
    assign epc        = epc_reg;
    assign cause      = cause_reg;
    assign in_service = (state_reg == SERVICE);

endmodule

// File: doc/mc_int_unit.md
Name: mc_int_unit

Overview:
- Parametrised interrupt unit for the multi-cycle CPU; gives the CPU-top INT path real semantics.
- Synchronises NUM_IRQ asynchronous request lines and latches their rising edges as pending.
- Presents the highest-priority enabled request to the multi-cycle controller, saves the return PC (EPC) when the controller accepts, and blocks further requests until ERET.
- Sits beside the controller and datapath inside the CPU top.

Parameters:
- NUM_IRQ, 4, number of request channels; index 0 has highest priority; range 1..16.
- ADDR_W, 32, PC/address width.
- SYNC_STAGES, 2, synchroniser flops per irq line; minimum 2.
- VEC_BASE, 32'h0000_0004, vector address of channel 0; truncated to ADDR_W.
- VEC_STRIDE, 8, byte distance between consecutive channel vectors.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- irq  in  NUM_IRQ  asynchronous request lines, level-high; the rising edge is the event.
- irq_en_wr  in  1  write strobe for the enable register.
- irq_en_din  in  NUM_IRQ  new enable value.
- irq_en  out  NUM_IRQ  enable register; 1 = channel may request.
- pending  out  NUM_IRQ  latched, not-yet-serviced edges.
- int_req  out  1  request to controller.
- int_vector  out  ADDR_W  handler address for the current winner; valid while int_req is high.
- int_ack  in  1  one-cycle pulse from the controller at an instruction boundary; PC loads int_vector in that cycle.
- pc_next  in  ADDR_W  address of the next instruction to execute; sampled on an accepted ack.
- eret  in  1  one-cycle pulse when the controller executes ERET.
- epc  out  ADDR_W  saved return address.
- cause  out  NUM_IRQ  one-hot channel being serviced.
- in_service  out  1  handler active (FSM state SERVICE).

Behaviour:
- Reset: all synchroniser flops, edge-history flops, pending, irq_en, epc, cause and in_service are 0. FSM is IDLE, so int_req = 0 and int_vector = VEC_BASE.
- Synchroniser and edge detect: irq[i] passes through a SYNC_STAGES-deep chain. rise[i] = sync_out & ~prev. If irq[i] is first sampled high at edge E0, pending[i] is high after edge E0+SYNC_STAGES. A pulse shorter than one clk period may be lost.
- Pending:
  - Set by rise[i] regardless of irq_en, so a masked edge is remembered.
  - Cleared only by an accepted ack, and only for the winning channel.
  - Set and clear on the same bit in the same cycle: set wins.
- Winner: lowest index i with pending[i] & irq_en[i].
  - int_req = (any winner) & ~in_service. Combinational, no extra latency.
  - int_vector = VEC_BASE + winner_idx*VEC_STRIDE, modulo 2^ADDR_W.
  - When there is no winner, int_vector = VEC_BASE.
- FSM IDLE -> SERVICE: int_ack & int_req in IDLE. Same edge: epc <= pc_next, cause <= one-hot(winner), pending[winner] cleared.
- FSM SERVICE -> IDLE: on eret. cause and epc hold their values; they are not cleared.
- Ignored events:
  - int_ack while int_req = 0 changes nothing.
  - eret in IDLE is ignored.
  - int_ack and eret in the same cycle: only eret acts, because int_req is low in SERVICE. A request may rise the next cycle.
- No nesting: in SERVICE, new edges still set pending, but int_req stays 0.
- irq_en_wr updates on the edge. The winner and int_req in that cycle use the old enable value. The register write and an ack in the same cycle are both applied.
- Reset asserted mid-service returns to the full reset state on that edge. Pending edges are discarded.
- All outputs are registers, except int_req and int_vector, which are combinational from registers only.

Test Plan:
- Reset then idle:
  - Stimulus: hold reset 3 cycles, then release.
  - Required: every output 0, int_vector = 32'h4, int_req stays 0 for 10 cycles with irq = 0.
- Latency and vector:
  - Stimulus: irq_en = 4'b1111; raise irq[2] at edge E0.
  - Required: pending = 4'b0100 after edge E0+2; int_req = 1; int_vector = 32'h14.
  - Then ack with pc_next = 32'h0000_0100: epc = 32'h100, cause = 4'b0100, in_service = 1, pending = 0, int_req = 0.
- Priority and no-nesting:
  - Stimulus: raise irq[3] and irq[1] in the same cycle.
  - Required: vector 32'hC.
  - Ack, then raise irq[0] during service: pending[0] = 1, int_req stays 0.
  - eret: int_req = 1 the next cycle with vector 32'h4.
- Masked latch:
  - Stimulus: irq_en = 0; edge on irq[1].
  - Required: pending = 4'b0010, int_req = 0.
  - Write irq_en = 4'b0010: int_req rises the cycle after the write edge.
- Corner pulses:
  - ack with int_req = 0: no state change.
  - eret in IDLE: no change.
  - Same-cycle set and clear of pending[0] on ack: pending[0] stays 1.
  - ack + eret in the same cycle during SERVICE: returns to IDLE, epc unchanged.
- Reset mid-service:
  - Stimulus: in SERVICE with pending = 4'b1000, assert reset 1 cycle.
  - Required: every register 0, no int_req after release.
